alu_serial_flags: RTL and testbench
===================================

# alu_serial_flags

Parametrised, multi-cycle adder/subtractor for the SAP datapath with registered result, status flags and an active-low tri-state bus driver. Operands are captured on a start strobe and summed SLICE bits per clock, LSB slice first, so the carry chain is cut to SLICE bits. On completion the result and flags register and `done` pulses; `bus_out` drives the result onto the shared W-bus only while enabled. Adds carry/borrow chaining (ADC/SBB) for multi-word arithmetic.

## Interface
- WIDTH, 8, operand/result width in bits
- SLICE, 4, bits summed per clock; must divide WIDTH; N = WIDTH/SLICE
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB
- start  input  1  request operation; accepted only when busy=0
- out_en_n  input  1  active-low bus enable
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  registered result, always visible
- bus_out  output  WIDTH  result when out_en_n=0, else high-Z
- flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 -> RUN: latch a, b' (b for ADD/ADC, ~b for SUB/SBB), cin (ADD 0, SUB 1, ADC flag_c, SBB flag_c), slice counter = 0.
- RUN: each clock add slice k of a and b' plus running carry; write slice k of internal sum; counter++. After slice N-1 -> DONE.
- DONE: result <= sum; flags written; done=1 for this cycle; start accepted (back-to-back), else -> IDLE.
- a, b, op, flag_c are sampled only on the accepting edge; changes during RUN ignored. start while busy=1 ignored, no queuing.
- Flags: C = carry out of MSB (SUB: C=1 means A>=B unsigned, no borrow); Z = (result==0); N = result[WIDTH-1]; V per Configuration.
- result and flags hold between operations; only DONE updates them.
- bus_out is purely combinational from result and out_en_n.

## Timing
- Start accepted at edge t0: busy=1 from t0.
- Slices computed at edges t0+1 .. t0+N; at edge t0+N result/flags update, done=1, busy=0.
- Edge t0+N+1: done=0 (unless a new start was accepted at t0+N+1's preceding cycle, then busy=1).
- Latency start->done N cycles; max throughput one op per N+1 cycles.
- Reset (async, any state): state IDLE, busy 0, done 0, result 0, all flags 0, internal sum/counter 0; bus_out = Z if out_en_n=1, else 0.
- Reset mid-RUN aborts; no partial result or flag ever reaches outputs.
- WIDTH == SLICE legal: N=1, single RUN cycle.

## Configuration
- ALU_SERIAL_FLAGS_OVF_EN defined: flag_v = signed overflow, (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), updated in DONE.
- Undefined: no overflow logic synthesised; flag_v constant 0.

## Test plan
- WIDTH=8, SLICE=4: reset, ADD 0x3C+0x14 -> result 0x50, C0 Z0 N0, busy 2 cycles, done at t0+2.
- SUB 0x05-0x05 -> 0x00, C1 Z1 N0; SUB 0x03-0x05 -> 0xFE, C0 Z0 N1.
- ADD 0x7F+0x01 -> 0x80, N1, V1 with ALU_SERIAL_FLAGS_OVF_EN, V0 without.
- Chaining: ADD 0xFF+0x01 -> 0x00 C1 Z1, then ADC 0x00+0x00 -> 0x01 C0; SUB 0x00-0x01 -> 0xFF C0, then SBB 0x01-0x00 -> 0x00 Z1 C1.
- start held high continuously: ops accepted at t0, t0+3, t0+6; start pulses during busy produce no extra done; operand change mid-RUN does not affect result.
- Assert rst at t0+1 of ADD 0x11+0x22 -> busy 0, done never pulses, result 0x00, flags 0; out_en_n=1 -> bus_out all Z, out_en_n=0 -> bus_out equals result.

Source files
------------

// File: rtl/alu_serial_flags.sv
// Multi-cycle SLICE-bit-per-clock adder/subtractor with registered result, status flags
// and active-low tri-state bus driver. Define ALU_SERIAL_FLAGS_OVF_EN to add the overflow flag.
`timescale 1ns/1ps
module alu_serial_flags #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             out_en_n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] bus_out,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [SLICE:0]   slice_sum;

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Handshake: start is accepted on any edge where the FSM is not in RUN
    // (IDLE or DONE); while busy=1 start is ignored and nothing is queued.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One slice of the carry chain; the final slice's sum is written straight into result.
    always_comb begin
        slice_sum = {1'b0, a_q[SLICE*int'(cnt) +: SLICE]}
                  + {1'b0, b_q[SLICE*int'(cnt) +: SLICE]}
                  + {{SLICE{1'b0}}, carry};
        sum_next = sum_q;
        sum_next[SLICE*int'(cnt) +: SLICE] = slice_sum[SLICE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= op[0] ? ~b : b;
            carry <= op[1] ? flag_c : op[0];
            sum_q <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_q <= sum_next;
            carry <= slice_sum[SLICE];
            cnt   <= last ? '0 : cnt + 1'b1;
            if (last) begin
                result <= sum_next;
                flag_c <= slice_sum[SLICE];
                flag_z <= (sum_next == '0);
                flag_n <= sum_next[WIDTH-1];
            end
        end
    end

`ifdef ALU_SERIAL_FLAGS_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_v <= 1'b0;
        end else if (state == RUN && last && !accept) begin
            flag_v <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
        end
    end
`else
    assign flag_v = 1'b0;
`endif

    assign bus_out = out_en_n ? {WIDTH{1'bz}} : result;

endmodule

// File: tb/tb_alu_serial_flags.sv
// Scoreboard bench for alu_serial_flags (WIDTH=8, SLICE=4): the driver pushes hand-computed
// results, a negedge monitor pops and compares them on every done pulse.
`timescale 1ns/1ps
module tb_alu_serial_flags;

    localparam int W = 8;
    localparam int S = 4;
    localparam int N = W / S;

`ifdef ALU_SERIAL_FLAGS_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         start;
    logic         out_en_n;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] bus_out;
    logic         flag_c, flag_z, flag_n, flag_v;

    alu_serial_flags #(.WIDTH(W), .SLICE(S)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
        .out_en_n(out_en_n), .busy(busy), .done(done), .result(result),
        .bus_out(bus_out), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .flag_v(flag_v)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required < 200000ns");
        $fatal(1, "timeout");
    end

    // scoreboard
    logic [W+3:0] exp_q[$];
    int           lat_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [W+3:0] e;
        int           ec;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pending op (cycle %0d)", cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = lat_q.pop_front();
                check("result_flags", {20'd0, result, flag_c, flag_z, flag_n, flag_v}, {20'd0, e});
                check("done_cycle", cyc, ec);
                if (!out_en_n) check("bus_out_drive", {24'd0, bus_out}, {24'd0, e[W+3:4]});
            end
        end
    end

    // driver tasks
    task automatic wait_idle();
        int k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop,
                         input logic [W-1:0] er, input logic ec, input logic ez,
                         input logic en, input logic ev);
        wait_idle();
        a     = ia;
        b     = ib;
        op    = iop;
        start = 1'b1;
        exp_q.push_back({er, ec, ez, en, ev});
        lat_q.push_back(cyc + 1 + N);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic [W-1:0] vr[3];
    logic [3:0]   vf[3];

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        op       = 2'b00;
        out_en_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags",  {28'd0, flag_c, flag_z, flag_n, flag_v}, 32'd0);
        check("reset_bus",    32'(bus_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD with explicit busy/done timing
        issue(8'h3C, 8'h14, 2'b00, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        check("add_busy_t0",  32'(busy), 32'd1);
        check("add_done_t0",  32'(done), 32'd0);
        @(negedge clk);
        check("add_busy_t1",  32'(busy), 32'd1);
        check("add_done_t1",  32'(done), 32'd0);
        @(negedge clk);
        check("add_busy_t2",  32'(busy), 32'd0);
        check("add_done_t2",  32'(done), 32'd1);
        drain();

        issue(8'h05, 8'h05, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(8'h03, 8'h05, 2'b01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1, OVF);
        issue(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(8'h00, 8'h00, 2'b10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(8'h01, 8'h00, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // start held high: accepts at t0, t0+3, t0+6; operands scrambled mid-RUN
        va[0] = 8'h10; vb[0] = 8'h20; vr[0] = 8'h30; vf[0] = 4'b0000;
        va[1] = 8'h80; vb[1] = 8'h80; vr[1] = 8'h00; vf[1] = {3'b110, OVF};
        va[2] = 8'h01; vb[2] = 8'hFE; vr[2] = 8'hFF; vf[2] = 4'b0010;
        wait_idle();
        op = 2'b00;
        for (int i = 0; i < 7; i++) begin
            if (i % 3 == 0) begin
                a = va[i/3];
                b = vb[i/3];
                exp_q.push_back({vr[i/3], vf[i/3]});
                lat_q.push_back(cyc + 1 + N);
            end else begin
                a = W'($urandom_range(0, 255));
                b = W'($urandom_range(0, 255));
            end
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // reset one edge into an ADD: aborted, nothing reaches outputs
        issue(8'h11, 8'h22, 2'b00, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        @(negedge clk);
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags",  {28'd0, flag_c, flag_z, flag_n, flag_v}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        out_en_n = 1'b1;
        #1;
        n_tests++;
        if (bus_out !== {W{1'bz}}) begin
            n_fail++;
            $display("FAIL bus_hiz: got %b, required all z", bus_out);
        end
        out_en_n = 1'b0;
        #1 check("bus_enabled", 32'(bus_out), 32'd0);

        // recovery after reset, then tri-state with a live result
        issue(8'h3C, 8'h14, 2'b00, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        out_en_n = 1'b1;
        #1;
        n_tests++;
        if (bus_out !== {W{1'bz}}) begin
            n_fail++;
            $display("FAIL bus_hiz_live: got %b, required all z", bus_out);
        end
        check("result_hold", 32'(result), 32'h50);
        out_en_n = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
